// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory loader.
package imem_pkg;

  localparam int INS_ADDRESS_DEF = 9;   // byte-address width of the instruction memory
  localparam int INS_W_DEF       = 32;  // instruction word width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into W-bit words (four bytes per word).
module imem_byte_packer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [7:0]   byte_in,
  output logic [W-1:0] word,
  output logic         last
);

  logic [1:0] cnt;

  // Shift each byte in from the top so the first byte ends up in bits 7:0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (load) begin
      cnt  <= cnt + 2'd1;
      word <= {byte_in, word[W-1:8]};
    end
  end

  // The byte being accepted while this is high completes the word.
  assign last = (cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the CPU in reset.
module imem_loader import imem_pkg::*; #(
  parameter int INS_ADDRESS = INS_ADDRESS_DEF,
  parameter int INS_W       = INS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [INS_ADDRESS-2:0] num_words,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   wr_en,
  output logic [INS_ADDRESS-1:0] wr_addr,
  output logic [INS_W-1:0]       wr_data,
  output logic                   cpu_hold,
  output logic                   done
);

  localparam int WIDX_W = INS_ADDRESS - 2;  // word index width
  localparam int CNT_W  = INS_ADDRESS - 1;  // word count width (holds capacity itself)
  localparam logic [CNT_W-1:0] CAP = CNT_W'(2 ** WIDX_W);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WIDX_W-1:0]  word_idx;
  logic [INS_ADDRESS-1:0] hold_addr, cur_addr;
  logic [INS_W-1:0]   hold_data, pk_word;
  logic               pk_clr, pk_load, pk_last;
  logic               last_word, load_go;
  logic [CNT_W-1:0]   count_in;

  imem_byte_packer #(.W(INS_W)) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (pk_clr),
    .load    (pk_load),
    .byte_in (rx_data),
    .word    (pk_word),
    .last    (pk_last)
  );

  // Requests beyond the memory are clipped so word_idx never wraps.
  assign count_in  = (num_words > CAP) ? CAP : num_words;
  assign cur_addr  = {word_idx, 2'b00};
  assign last_word = (({1'b0, word_idx} + CNT_W'(1)) == count);
  assign load_go   = (state == IDLE) && start && (num_words != '0);

  // Address/data follow the live word during a write and hold otherwise.
  assign wr_addr = wr_en ? cur_addr : hold_addr;
  assign wr_data = wr_en ? pk_word  : hold_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-state strobes; abort beats the write strobe.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    wr_en     = 1'b0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    pk_clr    = 1'b0;
    pk_load   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_words == '0) state_nxt = DONE;
          else begin
            state_nxt = RECV;
            pk_clr    = 1'b1;
          end
        end
      end
      RECV: begin
        rx_ready = 1'b1;
        cpu_hold = 1'b1;
        pk_load  = rx_valid;
        if (abort)                   state_nxt = IDLE;
        else if (rx_valid && pk_last) state_nxt = WRITE;
      end
      WRITE: begin
        cpu_hold = 1'b1;
        if (abort) state_nxt = IDLE;
        else begin
          wr_en     = 1'b1;
          state_nxt = last_word ? DONE : RECV;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word count/index bookkeeping and the held write address/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      word_idx  <= '0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      if (load_go) begin
        count    <= count_in;
        word_idx <= '0;
      end
      if (wr_en) begin
        hold_addr <= cur_addr;
        hold_data <= pk_word;
        // Stop at the final word so the index stays within capacity.
        if (!last_word) word_idx <= word_idx + WIDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int A = 9;

  logic         clk = 1'b0;
  logic         rst, start, abort, rx_valid;
  logic [A-2:0] num_words;
  logic [7:0]   rx_data;
  logic         rx_ready, wr_en, cpu_hold, done;
  logic [A-1:0] wr_addr;
  logic [31:0]  wr_data;

  imem_loader #(.INS_ADDRESS(A), .INS_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [A-1:0] a; logic [31:0] d; int c; } wr_t;
  wr_t wq[$];
  int  cyc = 0, n_chk = 0, n_err = 0;
  int  n_done, n_hold, n_rxr, n_xfer, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe one sample per cycle, after inputs driven on the falling edge settle.
  always begin
    @(negedge clk); #1;
    if (!rst) begin
      if (wr_en) wq.push_back('{a: wr_addr, d: wr_data, c: cyc});
      if (done) begin n_done++; done_cyc = cyc; end
      if (cpu_hold) n_hold++;
      if (rx_ready) n_rxr++;
      if (rx_ready && rx_valid) n_xfer++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    n_done = 0; n_hold = 0; n_rxr = 0; n_xfer = 0; done_cyc = -1;
  endtask

  // Offer one byte (optionally after a one-cycle gap) until it is taken.
  task automatic push_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      rx_valid = 1'b0;
      @(negedge clk);
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 20) begin @(negedge clk); n++; end
    if (!rx_ready) chk("rx_ready_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic start_load(input int nw);
    num_words = (A-1)'(nw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_basic(input bit gap);
    logic [7:0] prog [8];
    int c0;
    prog = '{8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    clear_mon();
    num_words = 8'd2;
    start = 1'b1;
    @(negedge clk);
    c0 = cyc;
    // In the gapped run start stays high into RECV, where it must be ignored.
    if (!gap) start = 1'b0;
    chk("hold_after_start", cpu_hold, 1);
    for (int i = 0; i < 8; i++) push_byte(prog[i], gap);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("basic_nwr", wq.size(), 2);
    if (wq.size() >= 2) begin
      chk("basic_a0", wq[0].a, 9'h000);
      chk("basic_d0", wq[0].d, 32'h00007033);
      chk("basic_a1", wq[1].a, 9'h004);
      chk("basic_d1", wq[1].d, 32'h00100093);
      chk("basic_c0", wq[0].c - c0, gap ? 8 : 4);
      chk("basic_c1", wq[1].c - c0, gap ? 16 : 9);
    end
    chk("basic_ndone", n_done, 1);
    chk("basic_done_cyc", done_cyc - c0, gap ? 17 : 10);
    chk("basic_nhold", n_hold, gap ? 17 : 10);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_words = '0;
    rx_data = '0; rx_valid = 1'b0;
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_wr_en",    wr_en, 0);
    chk("rst_wr_addr",  wr_addr, 0);
    chk("rst_wr_data",  wr_data, 0);
    chk("rst_cpu_hold", cpu_hold, 0);
    chk("rst_done",     done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_basic(1'b0);
    run_basic(1'b1);

    // Zero-length request completes immediately.
    clear_mon();
    start_load(0);
    chk("zero_done", done, 1);
    repeat (4) @(negedge clk);
    chk("zero_nwr", wq.size(), 0);
    chk("zero_nrxr", n_rxr, 0);
    chk("zero_nhold", n_hold, 0);
    chk("zero_ndone", n_done, 1);

    // Oversized request is clipped to memory capacity.
    clear_mon();
    start_load(200);
    for (int i = 0; i < 512; i++) push_byte(i[7:0], 1'b0);
    rx_data = 8'hEE;
    rx_valid = 1'b1;
    repeat (20) @(negedge clk);
    rx_valid = 1'b0;
    chk("clip_nxfer", n_xfer, 512);
    chk("clip_nwr", wq.size(), 128);
    chk("clip_ndone", n_done, 1);
    if (wq.size() == 128) begin
      chk("clip_last_a", wq[127].a, 9'h1FC);
      chk("clip_last_d", wq[127].d, 32'hFFFEFDFC);
      bad = 0;
      for (int k = 0; k < 128; k++) begin
        if (wq[k].a !== 9'(k * 4) ||
            wq[k].d !== {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}) bad++;
      end
      chk("clip_seq_bad", bad, 0);
    end

    // Abort mid-word, then a fresh single-word load.
    clear_mon();
    start_load(2);
    push_byte(8'h5A, 1'b0);
    push_byte(8'hA5, 1'b0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_hold", cpu_hold, 0);
    chk("abort_rx_ready", rx_ready, 0);
    chk("abort_wr_data_kept", wr_data, 32'hFFFEFDFC);
    repeat (3) @(negedge clk);
    chk("abort_nwr", wq.size(), 0);
    chk("abort_ndone", n_done, 0);
    clear_mon();
    start_load(1);
    push_byte(8'hAA, 1'b0); push_byte(8'hBB, 1'b0);
    push_byte(8'hCC, 1'b0); push_byte(8'hDD, 1'b0);
    repeat (3) @(negedge clk);
    chk("restart_nwr", wq.size(), 1);
    if (wq.size() >= 1) begin
      chk("restart_a", wq[0].a, 9'h000);
      chk("restart_d", wq[0].d, 32'hDDCCBBAA);
    end
    chk("restart_ndone", n_done, 1);

    // Asynchronous reset between clock edges in RECV.
    clear_mon();
    start_load(2);
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_cpu_hold", cpu_hold, 0);
    chk("arst_rx_ready", rx_ready, 0);
    chk("arst_wr_en",    wr_en, 0);
    chk("arst_wr_addr",  wr_addr, 0);
    chk("arst_wr_data",  wr_data, 0);
    chk("arst_done",     done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_mon();
    start_load(1);
    push_byte(8'h11, 1'b0); push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0); push_byte(8'h44, 1'b0);
    repeat (3) @(negedge clk);
    chk("arst_restart_nwr", wq.size(), 1);
    if (wq.size() >= 1) begin
      chk("arst_restart_a", wq[0].a, 9'h000);
      chk("arst_restart_d", wq[0].d, 32'h44332211);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter INS_ADDRESS, default 9: byte-address width of the instruction memory; capacity is 2**(INS_ADDRESS-2) words.
REQ-002 SHALL have parameter INS_W, default 32: instruction word width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1: cancels an in-progress load.
REQ-007 SHALL have port num_words, input, INS_ADDRESS-1: number of words to load, latched on start.
REQ-008 SHALL have port rx_data, input, 8: incoming program byte.
REQ-009 SHALL have port rx_valid, input, 1: rx_data is valid.
REQ-010 SHALL have port rx_ready, output, 1: the loader accepts a byte; a byte transfers when rx_valid and rx_ready are both high.
REQ-011 SHALL have port wr_en, output, 1: instruction-memory write strobe.
REQ-012 SHALL have port wr_addr, output, INS_ADDRESS: word-aligned byte address, bits [1:0] always 0.
REQ-013 SHALL have port wr_data, output, INS_W: instruction word to write.
REQ-014 SHALL have port cpu_hold, output, 1: holds the CPU/PC in reset while a load is active.
REQ-015 SHALL have port done, output, 1: one-cycle pulse when a load completes.

Function
REQ-016 SHALL implement the FSM states IDLE, RECV, WRITE and DONE, with a registered state.
REQ-017 IDLE: rx_ready=0, cpu_hold=0. On start: if num_words==0, go to DONE; otherwise latch min(num_words, 2**(INS_ADDRESS-2)), clear the byte and word counters, and go to RECV.
REQ-018 RECV: rx_ready=1, cpu_hold=1. Each transfer places the byte little-endian (first byte into bits 7:0, fourth into 31:24). The fourth byte moves the FSM to WRITE.
REQ-019 WRITE: lasts exactly one cycle. wr_en=1, wr_addr={word_idx,2'b00}, wr_data=the assembled word, rx_ready=0. word_idx then increments; go to DONE if word_idx+1 equals the latched count, else go to RECV.
REQ-020 DONE: lasts one cycle. done=1, cpu_hold=0, then go to IDLE.
REQ-021 Latency: wr_en SHALL assert in the cycle immediately after the fourth-byte transfer. The minimum time per word is 5 cycles.
REQ-022 When rx_valid is low in RECV, the loader SHALL wait indefinitely with all counters unchanged.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 abort in RECV or WRITE SHALL send the FSM to IDLE next cycle. abort has priority over wr_en in that cycle, the partial word is discarded, and done is not pulsed.
REQ-025 wr_addr and wr_data SHALL hold their last values when wr_en=0.
REQ-026 word_idx SHALL never exceed capacity-1, so wr_addr never wraps.

Reset
REQ-027 While rst is high, asynchronously: state=IDLE, all counters 0, and rx_ready, wr_en, wr_addr, wr_data, cpu_hold and done all 0.
REQ-028 Reset mid-load SHALL discard the partial word. Words already written are not undone. A subsequent start restarts at address 0.

Structure
REQ-029 The shared package imem_pkg SHALL hold the state enum type (IDLE/RECV/WRITE/DONE) and the INS_ADDRESS/INS_W default constants.
REQ-030 Byte-to-word packing SHALL sit in one sub-module, imem_byte_packer, which contains the 2-bit byte counter and the 32-bit shift/assembly register.

Verification
REQ-031 Basic load: num_words=2, start, then bytes 33 70 00 00 93 00 10 00 back-to-back -> writes 0x000/0x00007033 and 0x004/0x00100093. done pulses one cycle after the second write. cpu_hold is high from the cycle after start until done.
REQ-032 Gapped input: same stimulus with rx_valid toggling every other cycle -> identical writes. No wr_en occurs before each fourth byte.
REQ-033 Zero length: num_words=0, start -> done pulses the next cycle. wr_en, rx_ready and cpu_hold never assert.
REQ-034 Clipping: num_words=200 with 800 bytes offered -> exactly 128 writes, the last at wr_addr 0x1FC, then done. The 513th byte is not accepted.
REQ-035 Abort: abort after the 2nd byte of word 1 -> no wr_en, IDLE, cpu_hold=0. Restart with num_words=1 writes to address 0x000 from fresh bytes.
REQ-036 Async reset: rst asserted mid-RECV between clock edges -> all outputs read 0 before the next clk edge.
